bbox_collector: RTL

//  Receive side of the streamed bounding-box interface. Captures one frame's
//  box burst (label, parent, min/max), folds every child label into its root

---
 rtl/bbox_collector.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bbox_collector.sv
// Receive side of the streamed bounding-box interface: captures one frame's box burst,
// folds child labels into their roots and re-emits one merged box per object.
// Optional: define BBOX_SIZE_FILTER_EN to skip roots narrower/shorter than MIN_DIM.
module bbox_collector #(
  parameter int unsigned WIDTH_BITS  = 11,
  parameter int unsigned HEIGHT_BITS = 10,
  parameter int unsigned LABEL_WIDTH = 8,
  parameter int unsigned NUM_LABELS  = 1 << LABEL_WIDTH
`ifdef BBOX_SIZE_FILTER_EN
  ,
  parameter int unsigned MIN_DIM     = 2
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [LABEL_WIDTH-1:0] in_label,
  input  logic [LABEL_WIDTH-1:0] in_parent,
  input  logic [WIDTH_BITS-1:0]  in_min_x,
  input  logic [WIDTH_BITS-1:0]  in_max_x,
  input  logic [HEIGHT_BITS-1:0] in_min_y,
  input  logic [HEIGHT_BITS-1:0] in_max_y,
  input  logic                   in_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LABEL_WIDTH-1:0] out_label,
  output logic [WIDTH_BITS-1:0]  out_min_x,
  output logic [WIDTH_BITS-1:0]  out_max_x,
  output logic [HEIGHT_BITS-1:0] out_min_y,
  output logic [HEIGHT_BITS-1:0] out_max_y,
  output logic                   frame_done,
  output logic [LABEL_WIDTH-1:0] out_count,
  output logic                   busy,
  output logic                   drop
);

  localparam int unsigned LAST_IDX = NUM_LABELS - 1;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]  min_x;
    logic [WIDTH_BITS-1:0]  max_x;
    logic [HEIGHT_BITS-1:0] min_y;
    logic [HEIGHT_BITS-1:0] max_y;
  } box_t;

  typedef enum logic [1:0] {COLLECT, RESOLVE, EMIT, FLUSH} state_t;

  state_t                 state;
  logic [LABEL_WIDTH-1:0] idx;
  logic [NUM_LABELS-1:0]  tbl_valid;
  logic [LABEL_WIDTH-1:0] tbl_parent [NUM_LABELS];
  box_t                   tbl_box    [NUM_LABELS];

  box_t                   in_box_c;
  box_t                   cur_box_c;
  box_t                   par_box_c;
  box_t                   union_box_c;
  logic [LABEL_WIDTH-1:0] cur_parent_c;
  logic                   cur_valid_c;
  logic                   par_valid_c;
  logic                   collect_wr_c;
  logic                   merge_c;
  logic                   size_ok_c;
  logic                   emit_hit_c;
  logic                   scan_end_c;

  // Current scan entry, its parent, and their union.
  always_comb begin
    in_box_c     = '{min_x: in_min_x, max_x: in_max_x, min_y: in_min_y, max_y: in_max_y};
    cur_valid_c  = tbl_valid[idx];
    cur_parent_c = tbl_parent[idx];
    cur_box_c    = tbl_box[idx];
    par_valid_c  = tbl_valid[cur_parent_c];
    par_box_c    = tbl_box[cur_parent_c];
    union_box_c.min_x = (cur_box_c.min_x < par_box_c.min_x) ? cur_box_c.min_x : par_box_c.min_x;
    union_box_c.max_x = (cur_box_c.max_x > par_box_c.max_x) ? cur_box_c.max_x : par_box_c.max_x;
    union_box_c.min_y = (cur_box_c.min_y < par_box_c.min_y) ? cur_box_c.min_y : par_box_c.min_y;
    union_box_c.max_y = (cur_box_c.max_y > par_box_c.max_y) ? cur_box_c.max_y : par_box_c.max_y;
    collect_wr_c = (state == COLLECT) && in_valid && (in_label != '0);
    merge_c      = (state == RESOLVE) && cur_valid_c && (cur_parent_c != '0) && (cur_parent_c < idx);
    scan_end_c   = (idx == LABEL_WIDTH'(LAST_IDX));
  end

`ifdef BBOX_SIZE_FILTER_EN
  logic [WIDTH_BITS:0]  box_w_c;
  logic [HEIGHT_BITS:0] box_h_c;
  always_comb begin
    box_w_c   = {1'b0, cur_box_c.max_x} - {1'b0, cur_box_c.min_x} + (WIDTH_BITS+1)'(1);
    box_h_c   = {1'b0, cur_box_c.max_y} - {1'b0, cur_box_c.min_y} + (HEIGHT_BITS+1)'(1);
    size_ok_c = (box_w_c >= (WIDTH_BITS+1)'(MIN_DIM)) && (box_h_c >= (HEIGHT_BITS+1)'(MIN_DIM));
  end
`else
  assign size_ok_c = 1'b1;
`endif

  assign emit_hit_c = cur_valid_c && size_ok_c;

  // Table payload: no reset needed, every read is qualified by tbl_valid.
  always_ff @(posedge clk) begin
    if (collect_wr_c) begin
      tbl_parent[in_label] <= in_parent;
      tbl_box[in_label]    <= in_box_c;
    end else if (merge_c) begin
      tbl_box[cur_parent_c] <= par_valid_c ? union_box_c : cur_box_c;
      if (!par_valid_c) tbl_parent[cur_parent_c] <= cur_parent_c;
    end
  end

  // Control FSM, valid bits and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      idx        <= '0;
      tbl_valid  <= '0;
      out_valid  <= 1'b0;
      out_label  <= '0;
      out_min_x  <= '0;
      out_max_x  <= '0;
      out_min_y  <= '0;
      out_max_y  <= '0;
      frame_done <= 1'b0;
      out_count  <= '0;
      busy       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      drop       <= in_valid && (state != COLLECT);
      case (state)
        COLLECT: begin
          if (collect_wr_c) tbl_valid[in_label] <= 1'b1;
          if (in_done) begin
            state <= RESOLVE;
            idx   <= LABEL_WIDTH'(LAST_IDX);
            busy  <= 1'b1;
          end
        end
        RESOLVE: begin
          if (merge_c) begin
            tbl_valid[cur_parent_c] <= 1'b1;
            tbl_valid[idx]          <= 1'b0;
          end
          if (idx == LABEL_WIDTH'(1)) state <= EMIT;
          else                        idx   <= idx - LABEL_WIDTH'(1);
        end
        EMIT: begin
          if (out_valid) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_count <= (&out_count) ? out_count : out_count + LABEL_WIDTH'(1);
              if (scan_end_c) begin
                frame_done <= 1'b1;
                state      <= FLUSH;
              end else begin
                idx <= idx + LABEL_WIDTH'(1);
              end
            end
          end else if (emit_hit_c) begin
            out_valid <= 1'b1;
            out_label <= idx;
            out_min_x <= cur_box_c.min_x;
            out_max_x <= cur_box_c.max_x;
            out_min_y <= cur_box_c.min_y;
            out_max_y <= cur_box_c.max_y;
          end else if (scan_end_c) begin
            frame_done <= 1'b1;
            state      <= FLUSH;
          end else begin
            idx <= idx + LABEL_WIDTH'(1);
          end
        end
        FLUSH: begin
          tbl_valid <= '0;
          out_count <= '0;
          idx       <= '0;
          busy      <= 1'b0;
          state     <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
